// File: rtl/gshare_ctrl.sv
// Gshare branch predictor controller: 16 two-bit counters indexed by address XOR
// speculative global history, with arbitrated predict/update ports and a table re-init sequencer.
module gshare_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_req,
  input  logic [3:0]  pred_adrs,
  output logic        pred_gnt,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [3:0]  pred_idx,
  output logic [3:0]  pred_hist,
  input  logic        upd_req,
  input  logic [3:0]  upd_idx,
  input  logic [3:0]  upd_hist,
  input  logic        upd_taken,
  input  logic        upd_mispred,
  output logic        upd_gnt,
  input  logic        init_start,
  output logic        busy,
  output logic [3:0]  ghist,
  output logic [15:0] sram_out
);

  typedef enum logic [1:0] {IDLE, UPD_WR, INIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q [16];
  logic [3:0]  ghist_q, ghist_d;
  logic [1:0]  starv_q, starv_d;
  logic [3:0]  init_ptr_q;
  logic [3:0]  wr_idx_q;
  logic        wr_taken_q;
  logic        pred_valid_q, pred_taken_q;
  logic [3:0]  pred_idx_q, pred_hist_q;
  logic [3:0]  lookup_idx;
  logic        lookup_bit;
  logic        unused_hist_msb;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) sat_step = (c == 2'b11) ? c : c + 2'b01;
    else       sat_step = (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign lookup_idx      = pred_adrs ^ ghist_q;
  assign lookup_bit      = cnt_q[lookup_idx][1];
  assign unused_hist_msb = upd_hist[3];

  always_comb begin
    state_d  = state_q;
    ghist_d  = ghist_q;
    starv_d  = starv_q;
    pred_gnt = 1'b0;
    upd_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = INIT;
          ghist_d = 4'h0;
        end else if (upd_req && !(pred_req && starv_q == 2'd2)) begin
          // Updates normally win; a waiting predict gets through after two update grants.
          upd_gnt = 1'b1;
          state_d = UPD_WR;
          if (upd_mispred) ghist_d = {upd_hist[2:0], upd_taken};
          if (pred_req)    starv_d = starv_q + 2'd1;
        end else if (pred_req) begin
          pred_gnt = 1'b1;
          ghist_d  = {ghist_q[2:0], lookup_bit};
          starv_d  = 2'd0;
        end
      end
      UPD_WR:  state_d = IDLE;
      INIT:    if (init_ptr_q == 4'hf) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ghist_q    <= 4'h0;
      starv_q    <= 2'd0;
      init_ptr_q <= 4'h0;
      wr_idx_q   <= 4'h0;
      wr_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ghist_q    <= ghist_d;
      starv_q    <= starv_d;
      init_ptr_q <= (state_q == INIT) ? init_ptr_q + 4'h1 : 4'h0;
      if (upd_gnt) begin
        wr_idx_q   <= upd_idx;
        wr_taken_q <= upd_taken;
      end
    end
  end

  // Counter table: one write per cycle, either the init sweep or the deferred training write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) cnt_q[k] <= 2'b01;
    end else if (state_q == INIT) begin
      cnt_q[init_ptr_q] <= 2'b01;
    end else if (state_q == UPD_WR) begin
      cnt_q[wr_idx_q] <= sat_step(cnt_q[wr_idx_q], wr_taken_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= 4'h0;
      pred_hist_q  <= 4'h0;
    end else begin
      pred_valid_q <= pred_gnt;
      if (pred_gnt) begin
        pred_taken_q <= lookup_bit;
        pred_idx_q   <= lookup_idx;
        pred_hist_q  <= ghist_q;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++) sram_out[k] = cnt_q[k][1];
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;
  assign pred_hist  = pred_hist_q;
  assign busy       = (state_q == UPD_WR) || (state_q == INIT);
  assign ghist      = ghist_q;

endmodule

// File: doc/gshare_ctrl.md
GSHARE_CTRL -- requirements
Module: gshare_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pred_req, input, 1 bit: prediction request, held until granted.
REQ-004 SHALL have port pred_adrs, input, 4 bits: branch address bits.
REQ-005 SHALL have port pred_gnt, output, 1 bit: combinational grant; a prediction is accepted in the cycle where pred_req=1 and pred_gnt=1.
REQ-006 SHALL have port pred_valid, output, 1 bit: response strobe, one cycle.
REQ-007 SHALL have port pred_taken, output, 1 bit: predicted direction.
REQ-008 SHALL have port pred_idx, output, 4 bits: table index used.
REQ-009 SHALL have port pred_hist, output, 4 bits: history snapshot taken before the speculative shift.
REQ-010 SHALL have port upd_req, input, 1 bit: resolve/update request, held until granted.
REQ-011 SHALL have port upd_idx, input, 4 bits: index to train.
REQ-012 SHALL have port upd_hist, input, 4 bits: history snapshot returned from the prediction.
REQ-013 SHALL have port upd_taken, input, 1 bit: actual outcome.
REQ-014 SHALL have port upd_mispred, input, 1 bit: outcome differed from the prediction.
REQ-015 SHALL have port upd_gnt, output, 1 bit: combinational grant for updates.
REQ-016 SHALL have port init_start, input, 1 bit: table re-initialise pulse.
REQ-017 SHALL have port busy, output, 1 bit: high in UPD_WR and INIT.
REQ-018 SHALL have port ghist, output, 4 bits: speculative global history.
REQ-019 SHALL have port sram_out, output, 16 bits: bit i = MSB of counter i, driving the predictor table.

Function
REQ-020 SHALL hold 16 two-bit saturating counters cnt[0..15].
REQ-021 SHALL implement FSM states IDLE, UPD_WR and INIT.
REQ-022 In IDLE, SHALL apply this priority: init_start first, then upd_req, then pred_req. Exception: pred_req wins over upd_req when the starvation count is 2.
REQ-023 SHALL assert grants only in IDLE; in IDLE with init_start=1, neither grant is asserted.
REQ-024 On init_start in IDLE, SHALL go to INIT and clear ghist to 0 at that edge.
REQ-025 INIT SHALL write cnt[k]=2'b01 for k=0..15, one entry per cycle (16 cycles), then return to IDLE.
REQ-026 SHALL ignore init_start outside IDLE.
REQ-027 Predict grant in cycle N: idx = pred_adrs XOR ghist, and bit = cnt[idx][1].
REQ-028 At the end of cycle N, on a predict grant, SHALL shift ghist to {ghist[2:0], bit}.
REQ-029 In cycle N+1, SHALL drive pred_valid=1 together with pred_taken=bit, pred_idx=idx and pred_hist = ghist before the shift.
REQ-030 Update grant in cycle N: SHALL capture upd_idx and upd_taken, then go to UPD_WR.
REQ-031 At the end of cycle N, if upd_mispred=1, SHALL load ghist with {upd_hist[2:0], upd_taken}; otherwise ghist is unchanged.
REQ-032 In UPD_WR (cycle N+1), SHALL increment cnt[idx] when taken, saturating at 3.
REQ-033 In UPD_WR (cycle N+1), SHALL decrement cnt[idx] when not taken, saturating at 0.
REQ-034 SHALL return from UPD_WR to IDLE after one cycle; no grants are issued in UPD_WR.
REQ-035 SHALL increment the 2-bit starvation count on each update grant made while pred_req=1, and clear it on each predict grant.
REQ-036 SHALL make counter writes visible on sram_out the cycle after the write edge.
REQ-037 A prediction granted in the cycle after UPD_WR SHALL see the updated counter.

Reset
REQ-038 While rst_n=0, SHALL force all counters to 2'b01 (sram_out=16'h0000) and ghist=0.
REQ-039 While rst_n=0, SHALL force the FSM to IDLE and the starvation count to 0.
REQ-040 While rst_n=0, SHALL drive pred_valid, pred_taken, pred_idx, pred_hist and busy to 0.
REQ-041 Reset asserted mid-INIT or mid-UPD_WR SHALL abort the operation with no partial write surviving.

Verification
REQ-042 Reset, then pred_req with adrs=4'h5 -> pred_gnt same cycle; next cycle pred_valid=1, pred_taken=0, pred_idx=5, pred_hist=0; ghist=0.
REQ-043 Two taken updates to idx 3 (cnt 01->10->11) -> sram_out[3]=1; a third taken update leaves cnt=11; four not-taken updates leave cnt=00, with no underflow.
REQ-044 upd_req and pred_req held high together from IDLE -> grants in order U, U, P, U, U, P; busy=1 in each UPD_WR cycle.
REQ-045 ghist=4'b1011, then update with upd_mispred=1, upd_hist=4'b0110, upd_taken=1 -> ghist=4'b1101 after the grant edge.
REQ-046 Train several counters, then pulse init_start -> busy=1 for 16 cycles, no grants during that time, sram_out=0 and ghist=0 afterwards.
REQ-047 Drop rst_n in INIT cycle 7 -> all counters 01, FSM in IDLE, and pred_gnt is available on the first cycle after release.
